clk_div_prog: RTL and testbench

//  Programmable clock divider. Produces a 50%-duty divided clock (clk_out) plus a
//  one-cycle strobe (tick) at every half-period boundary, both synchronous to clk.

---
 rtl/clk_div_prog.sv | 94 +++++++++
 tb/tb_clk_div_prog.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_prog.sv
// Programmable 50%-duty clock divider with runt-free divisor reload and a tick strobe.
// Optional phase-restart input `sync` is built only when PHASE_SYNC_EN is defined.
module clk_div_prog #(
   parameter int          CNT_W        = 24,
   parameter int unsigned DEFAULT_HALF = 5000000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             load,
   input  logic [CNT_W-1:0] div_half,
`ifdef PHASE_SYNC_EN
   input  logic             sync,
`endif
   output logic             pending,
   output logic             clk_out,
   output logic             tick
);

   // A zero divisor behaves as one, including the reset default.
   localparam logic [CNT_W-1:0] RST_HALF =
      (DEFAULT_HALF == 0) ? CNT_W'(1) : CNT_W'(DEFAULT_HALF);

   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_div_act;
   logic [CNT_W-1:0] r_div_pend;
   logic             r_pending;
   logic             r_clk_out;
   logic             r_tick;

   logic [CNT_W-1:0] w_n_eff;
   logic             w_terminal;
   logic             w_boundary;

   assign w_n_eff    = (r_div_act == '0) ? CNT_W'(1) : r_div_act;
   assign w_terminal = en && (r_cnt == w_n_eff - CNT_W'(1));

`ifdef PHASE_SYNC_EN
   assign w_boundary = w_terminal | sync;
`else
   assign w_boundary = w_terminal;
`endif

   // Counter, divided clock and tick strobe.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt     <= '0;
         r_clk_out <= 1'b0;
         r_tick    <= 1'b0;
      end else begin
         // NOTE: every register here uses <= so all updates see pre-edge values.
         r_tick <= 1'b0;
`ifdef PHASE_SYNC_EN
         if (sync) begin
            r_cnt     <= '0;
            r_clk_out <= 1'b0;
         end else
`endif
         if (w_terminal) begin
            r_cnt     <= '0;
            r_clk_out <= ~r_clk_out;
            r_tick    <= 1'b1;
         end else if (en) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   // Divisor staging: a new value only becomes active at a half-period boundary,
   // so the half-period in progress is never cut short.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         // NOTE: only a handful of control flops, so all of them get a reset value.
         r_div_act  <= RST_HALF;
         r_div_pend <= '0;
         r_pending  <= 1'b0;
      end else if (w_boundary) begin
         if (load) begin
            r_div_act <= div_half;
         end else if (r_pending) begin
            r_div_act <= r_div_pend;
         end
         r_pending <= 1'b0;
      end else if (load) begin
         r_div_pend <= div_half;
         r_pending  <= 1'b1;
      end
   end

   assign pending = r_pending;
   assign clk_out = r_clk_out;
   assign tick    = r_tick;

endmodule

// File: tb/tb_clk_div_prog.sv
// Self-checking bench for clk_div_prog: a cycle model pushes expected outputs per edge,
// a negedge checker pops and compares; directed spot checks cover the key scenarios.
module tb_clk_div_prog;

   localparam int CNT_W = 8;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             en = 1'b0;
   logic             load = 1'b0;
   logic [CNT_W-1:0] div_half = '0;
   logic             sync = 1'b0;
   logic             pending;
   logic             clk_out;
   logic             tick;

   int n_total = 0;
   int n_bad   = 0;

   typedef struct packed {
      logic c;
      logic t;
      logic p;
   } exp_t;

   exp_t exp_q[$];

   clk_div_prog #(.CNT_W(CNT_W), .DEFAULT_HALF(5)) dut (
      .clk      (clk),
      .reset    (reset),
      .en       (en),
      .load     (load),
      .div_half (div_half),
`ifdef PHASE_SYNC_EN
      .sync     (sync),
`endif
      .pending  (pending),
      .clk_out  (clk_out),
      .tick     (tick)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: tracks cycles left in the current half-period.
   int unsigned m_half = 5;
   int unsigned m_pend_val = 0;
   int unsigned m_left = 5;
   logic        m_pend = 1'b0;
   logic        m_clk = 1'b0;
   logic        m_tick = 1'b0;

   function automatic int unsigned neff(input int unsigned v);
      return (v == 0) ? 1 : v;
   endfunction

   always @(posedge clk or negedge reset) begin
      int unsigned nxt;
      logic        do_sync;
      if (!reset) begin
         m_half = 5; m_pend = 1'b0; m_pend_val = 0;
         m_clk = 1'b0; m_tick = 1'b0; m_left = 5;
         exp_q.delete();
      end else begin
`ifdef PHASE_SYNC_EN
         do_sync = sync;
`else
         do_sync = 1'b0;
`endif
         nxt = load ? int'(div_half) : (m_pend ? m_pend_val : m_half);
         if (do_sync) begin
            m_half = nxt; m_pend = 1'b0;
            m_clk = 1'b0; m_tick = 1'b0; m_left = neff(nxt);
         end else if (en && m_left == 1) begin
            m_half = nxt; m_pend = 1'b0;
            m_clk = ~m_clk; m_tick = 1'b1; m_left = neff(nxt);
         end else begin
            m_tick = 1'b0;
            if (en) m_left = m_left - 1;
            if (load) begin
               m_pend_val = int'(div_half);
               m_pend = 1'b1;
            end
         end
         exp_q.push_back('{c: m_clk, t: m_tick, p: m_pend});
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (reset && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("sb_clk_out", 32'(clk_out), 32'(e.c));
         check("sb_tick",    32'(tick),    32'(e.t));
         check("sb_pending", 32'(pending), 32'(e.p));
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Async reset pulse placed between edges; outputs must clear without a clock.
   task automatic do_reset();
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      check("rst_clk_out", 32'(clk_out), 32'd0);
      check("rst_tick",    32'(tick),    32'd0);
      check("rst_pending", 32'(pending), 32'd0);
      en = 1'b0; load = 1'b0; sync = 1'b0;
      #1 reset = 1'b1;
   endtask

   task automatic pulse_load(input logic [CNT_W-1:0] v);
      load = 1'b1; div_half = v;
      cyc(1);
      load = 1'b0;
   endtask

   initial begin
      // Default half-period 5: first rise on edge 5, tick with it.
      do_reset();
      en = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         cyc(1);
         check("t1_clk_out", 32'(clk_out), 32'(k == 5));
         check("t1_tick",    32'(tick),    32'(k == 5));
      end
      cyc(5);
      check("t1_fall", 32'(clk_out), 32'd0);
      cyc(10);

      // Load 3 at cnt=1: first half-period keeps length 5.
      do_reset();
      en = 1'b1;
      cyc(1);
      pulse_load(8'd3);
      check("t2_pend_set", 32'(pending), 32'd1);
      cyc(2);
      check("t2_pend_hold", 32'(pending), 32'd1);
      cyc(1);
      check("t2_pend_clr", 32'(pending), 32'd0);
      check("t2_rise",     32'(clk_out), 32'd1);
      cyc(2);
      check("t2_high", 32'(clk_out), 32'd1);
      cyc(1);
      check("t2_fall3", 32'(clk_out), 32'd0);
      cyc(6);

      // Divisor 0 acts as 1: tick stays high.
      pulse_load(8'd0);
      cyc(6);
      check("t3_tick_a", 32'(tick), 32'd1);
      cyc(1);
      check("t3_tick_b", 32'(tick), 32'd1);
      en = 1'b0;
      pulse_load(8'd7);
      pulse_load(8'd9);
      check("t3_pend_9", 32'(pending), 32'd1);
      en = 1'b1;
      cyc(1);
      check("t3_applied", 32'(pending), 32'd0);
      cyc(40);

      // en low for 7 cycles at cnt=2; half-period completes 3 cycles after resume.
      do_reset();
      en = 1'b1;
      cyc(2);
      en = 1'b0;
      cyc(7);
      check("t4_frozen_clk", 32'(clk_out), 32'd0);
      check("t4_frozen_tick", 32'(tick), 32'd0);
      en = 1'b1;
      cyc(2);
      check("t4_not_yet", 32'(clk_out), 32'd0);
      cyc(1);
      check("t4_rise", 32'(clk_out), 32'd1);
      check("t4_tick", 32'(tick), 32'd1);

      // Mid-period reset with divisor 3 active, then default period again.
      pulse_load(8'd3);
      cyc(12);
      do_reset();
      en = 1'b1;
      cyc(4);
      check("t5_default_low", 32'(clk_out), 32'd0);
      cyc(1);
      check("t5_default_rise", 32'(clk_out), 32'd1);
      cyc(10);

`ifdef PHASE_SYNC_EN
      // sync at cnt=3 while clk_out high restarts the phase.
      do_reset();
      en = 1'b1;
      cyc(8);
      check("t6_pre_high", 32'(clk_out), 32'd1);
      sync = 1'b1;
      cyc(1);
      sync = 1'b0;
      check("t6_sync_low", 32'(clk_out), 32'd0);
      cyc(4);
      check("t6_still_low", 32'(clk_out), 32'd0);
      cyc(1);
      check("t6_rise", 32'(clk_out), 32'd1);
`endif

      // Random traffic against the model.
      for (int i = 0; i < 300; i++) begin
         en   = ($urandom_range(0, 7) != 0);
         load = ($urandom_range(0, 9) == 0);
         div_half = CNT_W'($urandom_range(0, 6));
`ifdef PHASE_SYNC_EN
         sync = ($urandom_range(0, 29) == 0);
`endif
         cyc(1);
      end
      load = 1'b0; sync = 1'b0;
      cyc(2);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
